// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types, funct3 codes and FSM encodings for the LSU SRAM initiator.
// Misalignment helper is only referenced when LSU_MISALIGN_CHK_EN is defined.
package lsu_mem_ctrl_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef struct packed {
        logic                 load;
        logic                 store;
        logic [2:0]           op;
        logic [CPU_WIDTH-1:0] addr;
        logic [CPU_WIDTH-1:0] wdata;
    } lsu_req_t;

    // Reserved funct3 codes fall through to word size.
    function automatic lsu_size_e lsu_size(input logic [2:0] op);
        case (op)
            LSU_B, LSU_BU: return SZ_B;
            LSU_H, LSU_HU: return SZ_H;
            default:       return SZ_W;
        endcase
    endfunction

    function automatic logic lsu_reserved(input logic [2:0] op);
        return !(op inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] a);
        case (lsu_size(op))
            SZ_H:    return a[0];
            SZ_W:    return (a != 2'b00) || lsu_reserved(op);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational byte-lane steering: store mask/data shift and load extract with
// sign/zero extension, all driven from the latched request.
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]           op_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [CPU_WIDTH-1:0] wdata_i,
    input  logic [CPU_WIDTH-1:0] rdata_i,
    output logic [3:0]           wmask_o,
    output logic [CPU_WIDTH-1:0] wdata_o,
    output logic [CPU_WIDTH-1:0] rdata_o
);

    lsu_size_e            size;
    logic                 sext;
    logic [1:0]           lane;
    logic [4:0]           shamt;
    logic [CPU_WIDTH-1:0] rsh;

    always_comb begin
        size    = lsu_size(op_i);
        sext    = ~op_i[2];
        lane    = 2'b00;
        shamt   = 5'd0;
        rsh     = rdata_i;
        wmask_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size)
            SZ_B: begin
                lane    = addr_lo_i;
                shamt   = {lane, 3'b000};
                rsh     = rdata_i >> shamt;
                wmask_o = 4'b0001 << lane;
                wdata_o = {24'h0, wdata_i[7:0]} << shamt;
                rdata_o = {{24{sext & rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                // Half uses a[1] only; a[0] is either ignored or trapped upstream.
                lane    = {addr_lo_i[1], 1'b0};
                shamt   = {lane, 3'b000};
                rsh     = rdata_i >> shamt;
                wmask_o = 4'b0011 << lane;
                wdata_o = {16'h0, wdata_i[15:0]} << shamt;
                rdata_o = {{16{sext & rsh[15]}}, rsh[15:0]};
            end
            default: begin
                wmask_o = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU SRAM initiator: one load/store in flight, single-cycle strobe, aligned result.
// Optional LSU_MISALIGN_CHK_EN traps misaligned/reserved accesses without touching memory.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_load,
    input  logic                 i_store,
    input  logic [2:0]           i_op,
    input  logic [CPU_WIDTH-1:0] i_addr,
    input  logic [CPU_WIDTH-1:0] i_wdata,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [CPU_WIDTH-1:0] o_rdata,
    output logic                 o_err,
    output logic                 o_pre_valid,
    output logic                 o_ren,
    output logic [CPU_WIDTH-1:0] o_raddr,
    input  logic [CPU_WIDTH-1:0] i_rdata,
    output logic                 o_wen,
    output logic [CPU_WIDTH-1:0] o_waddr,
    output logic [3:0]           o_wmask,
    output logic [CPU_WIDTH-1:0] o_wdata,
    input  logic                 i_mem_valid
);

    logic [1:0]           state_q, state_d;
    lsu_req_t             req_q, req_d;
    logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]           al_wmask;
    logic [CPU_WIDTH-1:0] al_wdata, al_rdata, word_addr;
    logic                 mem_req, in_req, in_resp, busy;

`ifdef LSU_MISALIGN_CHK_EN
    logic err_q, err_d, bad_req;
    assign bad_req = mem_req & lsu_misaligned(i_op, i_addr[1:0]);
`endif

    assign mem_req = i_load | i_store;

    lsu_mem_ctrl_align u_align (
        .op_i      (req_q.op),
        .addr_lo_i (req_q.addr[1:0]),
        .wdata_i   (req_q.wdata),
        .rdata_i   (i_rdata),
        .wmask_o   (al_wmask),
        .wdata_o   (al_wdata),
        .rdata_o   (al_rdata)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
`ifdef LSU_MISALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    rdata_d = '0;
`ifdef LSU_MISALIGN_CHK_EN
                    err_d   = 1'b0;
`endif
                    if (mem_req) begin
                        req_d   = '{load: i_load, store: i_store, op: i_op,
                                    addr: i_addr, wdata: i_wdata};
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_RESP;
                    end
`ifdef LSU_MISALIGN_CHK_EN
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
`endif
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_mem_valid) begin
                    rdata_d = req_q.load ? al_rdata : '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Strobes decode purely from state so they can never outlive the REQ cycle.
    assign in_req    = (state_q == ST_REQ);
    assign in_resp   = (state_q == ST_RESP);
    assign busy      = in_req | (state_q == ST_WAIT);
    assign word_addr = {req_q.addr[CPU_WIDTH-1:2], 2'b00};

    assign o_ready     = (state_q == ST_IDLE);
    assign o_pre_valid = in_req;
    assign o_ren       = in_req & req_q.load;
    assign o_wen       = in_req & req_q.store;
    assign o_raddr     = (busy & req_q.load)  ? word_addr : '0;
    assign o_waddr     = (busy & req_q.store) ? word_addr : '0;
    assign o_wmask     = (busy & req_q.store) ? al_wmask  : 4'b0000;
    assign o_wdata     = (busy & req_q.store) ? al_wdata  : '0;
    assign o_valid     = in_resp;
    assign o_rdata     = in_resp ? rdata_q : '0;
`ifdef LSU_MISALIGN_CHK_EN
    assign o_err       = in_resp & err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered one-cycle SRAM responder.
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_load = 1'b0;
    logic        i_store = 1'b0;
    logic [2:0]  i_op = 3'b000;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_pre_valid;
    logic        o_ren;
    logic [31:0] o_raddr;
    logic [31:0] i_rdata;
    logic        o_wen;
    logic [31:0] o_waddr;
    logic [3:0]  o_wmask;
    logic [31:0] o_wdata;
    logic        i_mem_valid;

    logic [31:0] mem_word = '0;
    int          strobe_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 i_clk = ~i_clk;

    lsu_mem_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_load      (i_load),
        .i_store     (i_store),
        .i_op        (i_op),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_pre_valid (o_pre_valid),
        .o_ren       (o_ren),
        .o_raddr     (o_raddr),
        .i_rdata     (i_rdata),
        .o_wen       (o_wen),
        .o_waddr     (o_waddr),
        .o_wmask     (o_wmask),
        .o_wdata     (o_wdata),
        .i_mem_valid (i_mem_valid)
    );

    // SRAM stand-in: answers one cycle after the strobe with the staged word.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            i_mem_valid <= 1'b0;
            i_rdata     <= '0;
        end else begin
            i_mem_valid <= o_pre_valid;
            i_rdata     <= o_pre_valid ? mem_word : 32'h0;
        end
    end

    always @(posedge i_clk) if (o_pre_valid) strobe_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h exp 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic ld, input logic st,
                          input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] mw,
                          input logic exp_mem, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int hold);
        int s0;
        @(negedge i_clk);
        i_valid = 1'b1; i_load = ld; i_store = st; i_op = op;
        i_addr = addr; i_wdata = wd; mem_word = mw;
        s0 = strobe_cnt;
        @(negedge i_clk);
        i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
        if (exp_mem) begin
            check({tag, "/pre_valid"}, 32'(o_pre_valid), 32'd1);
            check({tag, "/ren"}, 32'(o_ren), 32'(ld));
            check({tag, "/wen"}, 32'(o_wen), 32'(st));
            if (ld) check({tag, "/raddr"}, o_raddr, {addr[31:2], 2'b00});
            if (st) begin
                check({tag, "/waddr"}, o_waddr, {addr[31:2], 2'b00});
                check({tag, "/wmask"}, 32'(o_wmask), 32'(exp_mask));
                check({tag, "/wdata"}, o_wdata, exp_wd);
            end
            @(negedge i_clk);
            check({tag, "/wait_pv"}, 32'(o_pre_valid), 32'd0);
            check({tag, "/wait_vld"}, 32'(o_valid), 32'd0);
            @(negedge i_clk);
        end
        check({tag, "/valid"}, 32'(o_valid), 32'd1);
        check({tag, "/rdata"}, o_rdata, exp_rd);
        check({tag, "/err"}, 32'(o_err), 32'(exp_err));
        check({tag, "/ready_busy"}, 32'(o_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            check({tag, "/hold_vld"}, 32'(o_valid), 32'd1);
            check({tag, "/hold_rd"}, o_rdata, exp_rd);
            check({tag, "/hold_rdy"}, 32'(o_ready), 32'd0);
            check({tag, "/hold_pv"}, 32'(o_pre_valid), 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check({tag, "/idle_rdy"}, 32'(o_ready), 32'd1);
        check({tag, "/idle_vld"}, 32'(o_valid), 32'd0);
        check({tag, "/strobes"}, 32'(strobe_cnt - s0), 32'(exp_mem));
    endtask

    initial begin
        int s1;
        #1;
        check("rst/ready", 32'(o_ready), 32'd1);
        check("rst/valid", 32'(o_valid), 32'd0);
        check("rst/pre_valid", 32'(o_pre_valid), 32'd0);
        check("rst/ren_wen", 32'({o_ren, o_wen}), 32'd0);
        check("rst/wmask", 32'(o_wmask), 32'd0);
        check("rst/wdata", o_wdata, 32'd0);
        check("rst/rdata", o_rdata, 32'd0);
        check("rst/err", 32'(o_err), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        //     tag       ld    st    op      addr          wdata         mem word      mem   mask     wdata exp     rdata exp     err  hold
        run_op("sw",     1'b0, 1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        1'b1, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        run_op("sb",     1'b0, 1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0,        1'b1, 4'b1000, 32'hA5000000, 32'h0,        1'b0, 0);
        run_op("sh",     1'b0, 1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h0,        1'b1, 4'b1100, 32'hABCD0000, 32'h0,        1'b0, 0);
        run_op("lb",     1'b1, 1'b0, 3'b000, 32'h80000002, 32'h0,        32'h12F45678, 1'b1, 4'b0000, 32'h0,        32'hFFFFFFF4, 1'b0, 0);
        run_op("lbu",    1'b1, 1'b0, 3'b100, 32'h80000002, 32'h0,        32'h12F45678, 1'b1, 4'b0000, 32'h0,        32'h000000F4, 1'b0, 0);
        run_op("lh",     1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0,        32'h80011234, 1'b1, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0, 0);
        run_op("lhu",    1'b1, 1'b0, 3'b101, 32'h80000002, 32'h0,        32'h80011234, 1'b1, 4'b0000, 32'h0,        32'h00008001, 1'b0, 0);
        run_op("lh_lo",  1'b1, 1'b0, 3'b001, 32'h80000000, 32'h0,        32'h80011234, 1'b1, 4'b0000, 32'h0,        32'h00001234, 1'b0, 0);
        run_op("lw",     1'b1, 1'b0, 3'b010, 32'h80000008, 32'h0,        32'h13572468, 1'b1, 4'b0000, 32'h0,        32'h13572468, 1'b0, 0);
        run_op("nop",    1'b0, 1'b0, 3'b010, 32'h80000004, 32'h00001234, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0, 0);
        run_op("bp_lb",  1'b1, 1'b0, 3'b000, 32'h80000001, 32'h0,        32'h0000C300, 1'b1, 4'b0000, 32'h0,        32'hFFFFFFC3, 1'b0, 5);
`ifdef LSU_MISALIGN_CHK_EN
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h80000001, 32'h0,        32'hCAFEF00D, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0);
        run_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h80000001, 32'h0000BEEF, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0);
        run_op("rsv_op", 1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0,        32'hCAFEF00D, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 0);
`else
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h80000001, 32'h0,        32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 0);
        run_op("rsv_op", 1'b1, 1'b0, 3'b011, 32'h80000000, 32'h0,        32'hCAFEF00D, 1'b1, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 0);
        run_op("sw_mis", 1'b0, 1'b1, 3'b010, 32'h80000006, 32'h89ABCDEF, 32'h0,        1'b1, 4'b1111, 32'h89ABCDEF, 32'h0,        1'b0, 0);
`endif

        // Reset while the load is waiting for its response.
        @(negedge i_clk);
        i_valid = 1'b1; i_load = 1'b1; i_op = 3'b010; i_addr = 32'h80000010;
        mem_word = 32'h55AA55AA;
        @(negedge i_clk);
        i_valid = 1'b0; i_load = 1'b0;
        check("rstw/req_pv", 32'(o_pre_valid), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("rstw/ready", 32'(o_ready), 32'd1);
        check("rstw/valid", 32'(o_valid), 32'd0);
        check("rstw/pre_valid", 32'(o_pre_valid), 32'd0);
        check("rstw/raddr", o_raddr, 32'd0);
        s1 = strobe_cnt;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
        check("rstw/no_strobe", 32'(strobe_cnt - s1), 32'd0);
        check("rstw/idle_rdy", 32'(o_ready), 32'd1);
        check("rstw/idle_vld", 32'(o_valid), 32'd0);

        run_op("post_lw", 1'b1, 1'b0, 3'b010, 32'h8000000C, 32'h0, 32'h0BADF00D, 1'b1, 4'b0000, 32'h0, 32'h0BADF00D, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
